disp_serial_arb: RTL
====================

# disp_serial_arb

Arbiter and serial shift engine that shares one serial display bus (clock/data) between the 7-segment chain and the LED-bank chain of the board display subsystem. Each requester presents a parallel word with a level request. The block grants round-robin, shifts the word out MSB-first at a divided clock, then pulses that chain's latch enable and acknowledges. It sits between the ALU-result/page-select logic and the board's serial display pins.

## Interface
- SEG_W, 64, segment-chain word width (bits shifted per segment transfer)
- LED_W, 16, LED-chain word width
- DIV, 4, system clocks per serial-clock half period (≥1)
- REFRESH, 1048576, auto-refresh period in system clocks (used only with DISP_AUTOREFRESH_EN)
- clk  in  1  system clock; one clock, all logic on rising edge
- rstn  in  1  asynchronous, active-low reset
- seg_req  in  1  segment-chain transfer request (level)
- seg_data  in  SEG_W  segment word, sampled at grant
- seg_ack  out  1  one-cycle pulse: segment transfer latched
- led_req  in  1  LED-chain transfer request (level)
- led_data  in  LED_W  LED word, sampled at grant
- led_ack  out  1  one-cycle pulse: LED transfer latched
- busy  out  1  high from grant through ack cycle
- sclk  out  1  shared serial clock
- sdo  out  1  shared serial data
- seg_pen  out  1  segment-chain latch enable
- led_pen  out  1  LED-chain latch enable
- sclr  out  1  shared active-low chain clear

## Operation
- States: IDLE, SHIFT, LATCH, DONE.
- IDLE: sclk=0, sdo=0. If any request (external or refresh-pending) is present, grant one, capture its word into shift register, load bit counter = width−1, phase counter = 0, go SHIFT.
- Arbitration: round-robin pointer; only one requester → it wins; both → the one not served last; after reset, segment wins first tie.
- SHIFT: each bit occupies 2·DIV cycles: DIV cycles sclk=0, then DIV cycles sclk=1. sdo holds the current bit (MSB first) for all 2·DIV cycles; it changes only while sclk=0. After the last bit's high phase, go LATCH.
- LATCH: DIV cycles; sclk=0, sdo=0, granted chain's pen=1, the other 0.
- DONE: one cycle; granted ack=1, busy=1; pointer updated; go IDLE.
- Requests are levels held until ack. A request still high the cycle after ack is a new request. Data changes after grant are ignored. A request dropped mid-transfer does not abort it.
- sclr: 0 during reset, 1 from the first clock after reset release onward.

## Timing
- Reset values: sclk=0, sdo=0, seg_pen=0, led_pen=0, seg_ack=0, led_ack=0, busy=0, sclr=0; state IDLE; pointer favours segment; refresh counter 0; pending flags clear.
- Request sampled in IDLE at cycle 0. busy=1 from cycle 1. First bit on sdo at cycle 1.
- Ack asserted at cycle 1 + 2·DIV·N + DIV, where N is the word width. Defaults give cycle 133 for LED and 517 for segment. The next grant can occur in the cycle after the ack.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous). The transfer is lost, and no ack is issued.
- Counter widths: $clog2 of max(SEG_W, LED_W) and of DIV. No wrap within a transfer.

## Configuration
- DISP_AUTOREFRESH_EN defined:
  - A REFRESH-cycle free-running counter is compiled in.
  - At each expiry, a pending flag is set for every chain that has completed at least one transfer since reset.
  - A pending chain re-sends its last latched word, arbitrated identically to external requests.
  - A refresh transfer produces pen but no ack. The flag clears at its grant.
  - An external request for the same chain takes precedence over that chain's pending flag, uses the new data, and clears the flag.
- Undefined: no counter or flags; only external requests cause transfers.

## Test plan
- Single LED transfer, led_data=16'hA5C3, DIV=4:
  - sdo bit sequence 1010010111000011 sampled on sclk rising edges.
  - led_pen high 4 cycles.
  - led_ack at cycle 133.
  - seg_pen stays 0.
- Simultaneous seg_req and led_req from reset: segment is granted first (ack at 517); LED is granted at cycle 518 (ack at 518+133=651).
- Back-to-back: both requests held continuously. Grants alternate seg, led, seg, led. No idle gap beyond one IDLE cycle per transfer.
- Reset mid-shift: rstn low at bit 10 of a segment transfer.
  - All outputs go to 0 immediately, including sclr.
  - No seg_ack.
  - After release, the held request restarts from MSB.
- Data change after grant: seg_data toggled every cycle during a transfer. The shifted bits equal the value captured at grant.
- With DISP_AUTOREFRESH_EN and REFRESH=2000:
  - After one LED transfer, a refresh re-sends the same word with led_pen pulse and no led_ack.
  - The segment chain is never refreshed if it was never written.

Source files
------------

// File: rtl/disp_serial_arb_if.sv
// Display serial bus bundle: the request/data/ack handshakes of the two
// requesters plus the shared serial pins driven by the arbiter.
interface disp_serial_arb_if #(
  parameter int SEG_W = 64,
  parameter int LED_W = 16
);
  logic             seg_req;
  logic [SEG_W-1:0] seg_data;
  logic             seg_ack;
  logic             led_req;
  logic [LED_W-1:0] led_data;
  logic             led_ack;
  logic             busy;
  logic             sclk;
  logic             sdo;
  logic             seg_pen;
  logic             led_pen;
  logic             sclr;

  modport slave (
    input  seg_req, seg_data, led_req, led_data,
    output seg_ack, led_ack, busy, sclk, sdo, seg_pen, led_pen, sclr
  );

  modport master (
    output seg_req, seg_data, led_req, led_data,
    input  seg_ack, led_ack, busy, sclk, sdo, seg_pen, led_pen, sclr
  );
endinterface

// File: rtl/disp_serial_arb.sv
// disp_serial_arb: round-robin arbiter + MSB-first serial shifter sharing
// one display bus between the segment chain and the LED chain.
// Optional feature macro: DISP_AUTOREFRESH_EN (periodic re-send of the last
// latched word of every chain that has been written at least once).
module disp_serial_arb #(
  parameter int SEG_W   = 64,
  parameter int LED_W   = 16,
  parameter int DIV     = 4,
  parameter int REFRESH = 1048576
) (
  input  logic              clk,
  input  logic              rstn,
  disp_serial_arb_if.slave  bus
);

  // Words are left-aligned in an MW-wide shifter so the MSB is always bit MW-1.
  localparam int MW = (SEG_W > LED_W) ? SEG_W : LED_W;
  localparam int CW = (MW > 1) ? $clog2(MW) : 1;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(DIV - 1);
  localparam logic [CW-1:0] SEG_LAST = CW'(SEG_W - 1);
  localparam logic [CW-1:0] LED_LAST = CW'(LED_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;

  state_t        state;
  logic [MW-1:0] shreg;
  logic [CW-1:0] bit_cnt;
  logic [PW-1:0] ph_cnt;
  logic          gnt_led, gnt_ref, prio_led;
  logic          sclk_r, sdo_r, seg_pen_r, led_pen_r;
  logic          seg_ack_r, led_ack_r, busy_r, sclr_r;

  logic          seg_want, led_want, pick_led, pick_ref;
  logic [MW-1:0] seg_word, led_word, pick_word;

`ifdef DISP_AUTOREFRESH_EN
  localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  logic [RW-1:0] ref_cnt;
  logic          ref_tick;
  logic          seg_pend, led_pend, seg_done, led_done;
  logic [MW-1:0] cur_word, seg_last, led_last;

  assign ref_tick = (ref_cnt == RW'(REFRESH - 1));

  // Free-running refresh period counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ref_cnt <= '0;
    else       ref_cnt <= ref_tick ? '0 : ref_cnt + 1'b1;
  end
`else
  // REFRESH only matters when the refresh engine is compiled in.
  if (REFRESH < 1) begin : g_refresh_unused
  end
`endif

  // Request resolution: external request beats a pending refresh of the same
  // chain; on a tie the chain not served last wins.
  always_comb begin
    seg_word = MW'(bus.seg_data) << (MW - SEG_W);
    led_word = MW'(bus.led_data) << (MW - LED_W);
    seg_want = bus.seg_req;
    led_want = bus.led_req;
`ifdef DISP_AUTOREFRESH_EN
    if (!bus.seg_req) seg_word = seg_last;
    if (!bus.led_req) led_word = led_last;
    seg_want = bus.seg_req | seg_pend;
    led_want = bus.led_req | led_pend;
`endif
    pick_led  = led_want & (~seg_want | prio_led);
    pick_word = pick_led ? led_word : seg_word;
    // A grant without the external request behind it is a refresh.
    pick_ref  = pick_led ? ~bus.led_req : ~bus.seg_req;
  end

  // Main FSM: grant, shift at 2*DIV cycles per bit, latch pulse, ack.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      ph_cnt    <= '0;
      gnt_led   <= 1'b0;
      gnt_ref   <= 1'b0;
      prio_led  <= 1'b0;
      sclk_r    <= 1'b0;
      sdo_r     <= 1'b0;
      seg_pen_r <= 1'b0;
      led_pen_r <= 1'b0;
      seg_ack_r <= 1'b0;
      led_ack_r <= 1'b0;
      busy_r    <= 1'b0;
      sclr_r    <= 1'b0;
`ifdef DISP_AUTOREFRESH_EN
      seg_pend  <= 1'b0;
      led_pend  <= 1'b0;
      seg_done  <= 1'b0;
      led_done  <= 1'b0;
      cur_word  <= '0;
      seg_last  <= '0;
      led_last  <= '0;
`endif
    end else begin
      sclr_r <= 1'b1;
      case (state)
        IDLE: begin
          if (seg_want | led_want) begin
            state   <= SHIFT;
            gnt_led <= pick_led;
            gnt_ref <= pick_ref;
            sdo_r   <= pick_word[MW-1];
            shreg   <= pick_word << 1;
            bit_cnt <= pick_led ? LED_LAST : SEG_LAST;
            ph_cnt  <= '0;
            sclk_r  <= 1'b0;
            busy_r  <= 1'b1;
`ifdef DISP_AUTOREFRESH_EN
            cur_word <= pick_word;
            if (pick_led) led_pend <= 1'b0;
            else          seg_pend <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          if (ph_cnt != PH_LAST) begin
            ph_cnt <= ph_cnt + 1'b1;
          end else begin
            ph_cnt <= '0;
            if (!sclk_r) begin
              sclk_r <= 1'b1;
            end else if (bit_cnt == '0) begin
              state     <= LATCH;
              sclk_r    <= 1'b0;
              sdo_r     <= 1'b0;
              seg_pen_r <= ~gnt_led;
              led_pen_r <= gnt_led;
            end else begin
              sclk_r  <= 1'b0;
              sdo_r   <= shreg[MW-1];
              shreg   <= shreg << 1;
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end
        LATCH: begin
          if (ph_cnt != PH_LAST) begin
            ph_cnt <= ph_cnt + 1'b1;
          end else begin
            ph_cnt    <= '0;
            state     <= DONE;
            seg_pen_r <= 1'b0;
            led_pen_r <= 1'b0;
            seg_ack_r <= ~gnt_led & ~gnt_ref;
            led_ack_r <= gnt_led & ~gnt_ref;
`ifdef DISP_AUTOREFRESH_EN
            if (gnt_led) begin led_last <= cur_word; led_done <= 1'b1; end
            else         begin seg_last <= cur_word; seg_done <= 1'b1; end
`endif
          end
        end
        DONE: begin
          state     <= IDLE;
          seg_ack_r <= 1'b0;
          led_ack_r <= 1'b0;
          busy_r    <= 1'b0;
          prio_led  <= ~gnt_led;
        end
        default: state <= IDLE;
      endcase
`ifdef DISP_AUTOREFRESH_EN
      if (ref_tick) begin
        if (seg_done) seg_pend <= 1'b1;
        if (led_done) led_pend <= 1'b1;
      end
`endif
    end
  end

  assign bus.sclk    = sclk_r;
  assign bus.sdo     = sdo_r;
  assign bus.seg_pen = seg_pen_r;
  assign bus.led_pen = led_pen_r;
  assign bus.seg_ack = seg_ack_r;
  assign bus.led_ack = led_ack_r;
  assign bus.busy    = busy_r;
  assign bus.sclr    = sclr_r;

endmodule
